// File: rtl/cheese_ctl_pkg.sv
// cheese_ctl_pkg
// Shared constants, the controller state type and the helper functions used
// by the cheese controller and its sub-modules.
// - Playfield limits for cheese placement (CHEESE_X_MIN / CHEESE_Y_MIN).
// - Sprite sizes for the player and the cheese.
// - Galois feedback mask for the 16-bit position LFSR.
// - boxes_overlap(): strict axis-aligned box test (touching edges do not hit).
// - candidate_x/y(): map an LFSR value to an on-screen spawn position.
package cheese_ctl_pkg;

    localparam logic [10:0] CHEESE_X_MIN  = 11'd64;
    localparam logic [10:0] CHEESE_Y_MIN  = 11'd64;
    localparam logic [10:0] CHEESE_WIDTH  = 11'd32;
    localparam logic [10:0] CHEESE_HEIGHT = 11'd32;
    localparam logic [10:0] PLAYER_W      = 11'd32;
    localparam logic [10:0] PLAYER_H      = 11'd32;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SPAWN,
        ST_ACTIVE,
        ST_WAIT
    } cheese_state_t;

    // All sums wrap at 11 bits, matching the pixel coordinate datapath.
    function automatic logic boxes_overlap(
        input logic [10:0] px,
        input logic [10:0] py,
        input logic [10:0] cx,
        input logic [10:0] cy
    );
        logic [10:0] p_right, p_bottom, c_right, c_bottom;
        p_right  = px + PLAYER_W;
        p_bottom = py + PLAYER_H;
        c_right  = cx + CHEESE_WIDTH;
        c_bottom = cy + CHEESE_HEIGHT;
        return (px < c_right) && (cx < p_right) &&
               (py < c_bottom) && (cy < p_bottom);
    endfunction

    // x covers 64..575 using the low nine LFSR bits.
    function automatic logic [10:0] candidate_x(input logic [15:0] l);
        return CHEESE_X_MIN + {2'b00, l[8:0]};
    endfunction

    // y covers 64..318 in even steps using the upper seven LFSR bits.
    function automatic logic [10:0] candidate_y(input logic [15:0] l);
        return CHEESE_Y_MIN + {3'b000, l[15:9], 1'b0};
    endfunction

endpackage

// File: rtl/cheese_ctl_if.sv
// cheese_ctl_if
// Bundles the cheese controller's game-side signals.
// master: drives vblnk, start, player_x, player_y; observes the cheese outputs.
// slave : the controller; drives cheese_x, cheese_y, visible, collected,
//         expired and score.
interface cheese_ctl_if #(
    parameter int SCORE_W = 8
);
    logic               vblnk;
    logic               start;
    logic [10:0]        player_x;
    logic [10:0]        player_y;
    logic [10:0]        cheese_x;
    logic [10:0]        cheese_y;
    logic               visible;
    logic               collected;
    logic               expired;
    logic [SCORE_W-1:0] score;

    modport master (
        output vblnk, start, player_x, player_y,
        input  cheese_x, cheese_y, visible, collected, expired, score
    );

    modport slave (
        input  vblnk, start, player_x, player_y,
        output cheese_x, cheese_y, visible, collected, expired, score
    );
endinterface

// File: rtl/cheese_ctl_lfsr16.sv
// lfsr16
// 16-bit Galois LFSR that advances every clock and supplies spawn positions.
// Ports:
//   clk   in  1   clock
//   rst   in  1   synchronous active-high reset, loads seed
//   seed  in  16  reset / recovery value (must be nonzero)
//   value out 16  current LFSR state
module lfsr16
    import cheese_ctl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    // A zero state would lock the register, so it is replaced by the seed.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= seed;
        end else if (value == 16'd0) begin
            value <= seed;
        end else begin
            value <= (value >> 1) ^ (value[0] ? LFSR_MASK : 16'h0000);
        end
    end

endmodule

// File: rtl/cheese_ctl.sv
// cheese_ctl
// Owns the cheese sprite: spawns it at pseudo-random positions during
// vertical blanking, detects collection by the player box once per frame,
// keeps a saturating score and schedules the respawn after a frame delay.
// Ports:
//   clk  in  1  pixel clock
//   rst  in  1  synchronous active-high reset
//   bus  slave modport of cheese_ctl_if (vblnk, start, player_x/y in;
//        cheese_x/y, visible, collected, expired, score out)
// Optional feature macro: CHEESE_TIMEOUT_EN -- an uncollected cheese is
// relocated after TIMEOUT_FRAMES frames with a one-cycle expired pulse.
// Without it expired is held at 0.
module cheese_ctl
    import cheese_ctl_pkg::*;
#(
    parameter int          RESPAWN_FRAMES = 60,
    parameter int          TIMEOUT_FRAMES = 600,
    parameter int          SCORE_W        = 8,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    cheese_ctl_if.slave bus
);

    localparam int CNT_MAX = (RESPAWN_FRAMES > TIMEOUT_FRAMES) ? RESPAWN_FRAMES : TIMEOUT_FRAMES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] RESPAWN_LAST = CNT_W'(RESPAWN_FRAMES - 1);
`ifdef CHEESE_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_FRAMES - 1);
`endif

    cheese_state_t      state;
    logic [15:0]        lfsr;
    logic [10:0]        cheese_x_q;
    logic [10:0]        cheese_y_q;
    logic               visible_q;
    logic               collected_q;
    logic [SCORE_W-1:0] score_q;
    logic [CNT_W-1:0]   cnt;
    logic               vblnk_q;
    logic               tick_q;
    logic [10:0]        cand_x;
    logic [10:0]        cand_y;
    logic               spawn_hit;
    logic               catch_hit;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .seed  (LFSR_SEED),
        .value (lfsr)
    );

    assign cand_x    = candidate_x(lfsr);
    assign cand_y    = candidate_y(lfsr);
    assign spawn_hit = boxes_overlap(bus.player_x, bus.player_y, cand_x, cand_y);
    assign catch_hit = boxes_overlap(bus.player_x, bus.player_y, cheese_x_q, cheese_y_q);

`ifdef CHEESE_TIMEOUT_EN
    logic expired_q;
    assign bus.expired = expired_q;
`else
    assign bus.expired = 1'b0;
`endif

    // Frame tick is registered so it lands one cycle after vblnk rises; the
    // FSM then reacts on the following edge. start overrides every state
    // transition, including a collection on the same tick. Spawning only
    // commits while vblnk is high so the sprite never moves mid-frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cheese_x_q  <= CHEESE_X_MIN;
            cheese_y_q  <= CHEESE_Y_MIN;
            visible_q   <= 1'b0;
            collected_q <= 1'b0;
            score_q     <= '0;
            cnt         <= '0;
            vblnk_q     <= 1'b0;
            tick_q      <= 1'b0;
`ifdef CHEESE_TIMEOUT_EN
            expired_q   <= 1'b0;
`endif
        end else begin
            vblnk_q     <= bus.vblnk;
            tick_q      <= bus.vblnk & ~vblnk_q;
            collected_q <= 1'b0;
`ifdef CHEESE_TIMEOUT_EN
            expired_q   <= 1'b0;
`endif
            if (bus.start) begin
                score_q   <= '0;
                cnt       <= '0;
                visible_q <= 1'b0;
                state     <= ST_SPAWN;
            end else begin
                case (state)
                    ST_IDLE: begin
                    end
                    ST_SPAWN: begin
                        if (bus.vblnk && !spawn_hit) begin
                            cheese_x_q <= cand_x;
                            cheese_y_q <= cand_y;
                            visible_q  <= 1'b1;
                            cnt        <= '0;
                            state      <= ST_ACTIVE;
                        end
                    end
                    ST_ACTIVE: begin
                        if (tick_q) begin
                            if (catch_hit) begin
                                collected_q <= 1'b1;
                                if (score_q != {SCORE_W{1'b1}}) begin
                                    score_q <= score_q + SCORE_W'(1);
                                end
                                visible_q <= 1'b0;
                                cnt       <= '0;
                                state     <= ST_WAIT;
                            end
`ifdef CHEESE_TIMEOUT_EN
                            else if (cnt == TIMEOUT_LAST) begin
                                expired_q <= 1'b1;
                                state     <= ST_SPAWN;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
`endif
                        end
                    end
                    ST_WAIT: begin
                        if (tick_q) begin
                            if (cnt == RESPAWN_LAST) begin
                                state <= ST_SPAWN;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.cheese_x  = cheese_x_q;
    assign bus.cheese_y  = cheese_y_q;
    assign bus.visible   = visible_q;
    assign bus.collected = collected_q;
    assign bus.score     = score_q;

endmodule

// File: doc/cheese_ctl.md
# cheese_ctl

Game-logic controller that owns the cheese sprite's position and lifecycle. It spawns the cheese at pseudo-random on-screen coordinates and detects collection by the player's bounding box. It counts the score and schedules respawn after a frame-counted delay. Outputs feed the cheese draw stage's position interface and the HUD score path; all position changes commit only during vertical blanking, so the sprite never tears mid-frame.

## Interface
Parameters:
- RESPAWN_FRAMES, 60: frames between collection and the next spawn.
- TIMEOUT_FRAMES, 600: frames an uncollected cheese stays before relocating (only with CHEESE_TIMEOUT_EN).
- SCORE_W, 8: score counter width.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  pixel clock.
- rst  in  1  synchronous active-high reset.
- vblnk  in  1  vertical blank from the VGA timing chain.
- start  in  1  one-cycle pulse; clears the score and begins a round.
- player_x  in  11  player sprite top-left x.
- player_y  in  11  player sprite top-left y.
- cheese_x  out  11  cheese top-left x, to the draw stage.
- cheese_y  out  11  cheese top-left y.
- visible  out  1  cheese is to be drawn.
- collected  out  1  one-cycle pulse per collection.
- expired  out  1  one-cycle pulse on timeout relocation.
- score  out  SCORE_W  collections this round, saturating.

## Operation
- Frame tick: a one-cycle internal pulse on the rising edge of vblnk (registered vblnk_q; tick = vblnk & ~vblnk_q).
- LFSR: 16-bit Galois, mask 16'hB400, advances every clk in all states. A zero value reloads LFSR_SEED.
- Candidate position: x = CHEESE_X_MIN + lfsr[8:0] (range 64..575); y = CHEESE_Y_MIN + {lfsr[15:9],1'b0} (range 64..318). All arithmetic is 11-bit unsigned.
- Overlap: axis-aligned box test between player (PLAYER_W×PLAYER_H) and cheese (CHEESE_WIDTH×CHEESE_HEIGHT). Uses strict inequalities, so touching edges do not count as overlap.
- FSM states:
  - IDLE (reset state): visible=0. start → SPAWN.
  - SPAWN: each cycle while vblnk=1, evaluate the current candidate. On no overlap, latch cheese_x/y, set visible=1, clear the frame counter, go to ACTIVE. On overlap, stay and retry next cycle with the advanced LFSR. While vblnk=0, wait; no commit occurs outside blanking.
  - ACTIVE: on each frame tick, if the player overlaps the cheese: pulse collected, increment score (saturate at all ones), set visible=0, clear the counter, go to WAIT.
  - WAIT: count frame ticks. When the count reaches RESPAWN_FRAMES-1 on a tick, go to SPAWN.
- start in any state: clear score and counter, visible=0, go to SPAWN. start takes priority over every same-cycle transition, including a collection.
- Collection and timeout on the same tick: collection wins; expired is not pulsed.

## Timing
- Reset values: cheese_x=CHEESE_X_MIN, cheese_y=CHEESE_Y_MIN, visible=0, collected=0, expired=0, score=0, state IDLE, LFSR=LFSR_SEED, counter=0.
- All outputs are registered.
- collected and visible falling take effect 1 cycle after the clock edge on which the tick is seen. The tick itself is 1 cycle after vblnk rises, so collected asserts 2 clk after vblnk rises.
- SPAWN commit is 1 clk after the first vblnk-high cycle with a non-overlapping candidate.
- Respawn delay: exactly RESPAWN_FRAMES ticks from collection to the SPAWN entry.
- Reset mid-round: returns to IDLE in one cycle; score is lost.

## Configuration
- CHEESE_TIMEOUT_EN defined: in ACTIVE, the frame counter increments per tick. When the count reaches TIMEOUT_FRAMES-1 on a tick without collection: pulse expired, visible stays 1, go to SPAWN, score unchanged. The next SPAWN commit happens within the same blanking interval where possible.
- Not defined: ACTIVE waits indefinitely; expired is tied to 0; the timeout compare logic is absent.

## Structure
- game_pkg holds CHEESE_X_MIN=64, CHEESE_Y_MIN=64, PLAYER_W, PLAYER_H, and the cheese_state_t enum. CHEESE_WIDTH and CHEESE_HEIGHT already exist there.
- Sub-module lfsr16 (clk, rst, seed → 16-bit value, zero-recovery).
- Overlap test is a package function used in both SPAWN and ACTIVE.

## Test plan
- Reset, then start with the player at (700,550) and vblnk high → visible=1 within 2 clk; cheese_x in 64..575, cheese_y in 64..318.
- Hold the player on top of the cheese → collected pulse 2 clk after the next vblnk rise; score=1; visible=0. After 60 ticks the cheese reappears and a new SPAWN commit occurs.
- 300 consecutive collections with SCORE_W=8 → score saturates at 255 and never wraps.
- Force LFSR candidates that overlap the player → no commit until a non-overlapping candidate; the committed box never intersects the player box.
- CHEESE_TIMEOUT_EN, player far away → expired pulse on tick 600; new position committed; score unchanged. Without the macro, expired stays 0 for 2000 frames.
- start pulse coincident with a collection tick → score=0, state SPAWN, and no collected pulse; assert rst mid-WAIT → all outputs at reset values on the next cycle.
